// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: instruction field positions, reset vector,
// fetch FSM states and the buffered fetch entry.
package mips_pkg;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and the decoder-side valid/ready head.
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  if_op;
    logic [5:0]  if_funct;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_op, if_funct,
        input  imem_ack, imem_rdata, redirect, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_op, if_funct,
        output imem_ack, imem_rdata, redirect, redirect_pc, if_ready
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: DEPTH-entry buffer of {pc, instr} with push, pop, synchronous
// flush and full/empty flags. DEPTH must be a power of two (2 or 4).
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM feeding a small buffer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  imem_addr_q;
    logic         imem_req_q;
    logic [31:0]  redirect_target;
    logic         unused_redirect_lsbs;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_head;

    assign redirect_target      = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // Redirect beats a coincident ack: the returned word belongs to the old path.
    assign fifo_push = (state_q == WAIT) && bus.imem_ack && !bus.redirect;
    assign fifo_pop  = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.redirect) begin
                        pc_q <= redirect_target;
                    end else if (!fifo_full) begin
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= IDLE;
                        pc_q       <= bus.redirect ? redirect_target : pc_q + 32'd4;
                    end else if (bus.redirect) begin
                        pc_q    <= redirect_target;
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (bus.redirect) begin
                        pc_q <= redirect_target;
                    end
                    if (bus.imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_data_i({pc_q, bus.imem_rdata}),
        .pop_i      (fifo_pop),
        .flush_i    (bus.redirect),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.if_valid  = !fifo_empty;
    assign bus.if_instr  = fifo_head.instr;
    assign bus.if_pc     = fifo_head.pc;
    assign bus.if_op     = fifo_head.instr[OP_MSB:OP_LSB];
    assign bus.if_funct  = fifo_head.instr[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (fifo_pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (bus.if_ready && !bus.if_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a transaction-level model of the
// fetch stream predicts every request address and every delivered instruction.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int unsigned cycles;
        int unsigned p_ready;
        int unsigned lat_max;
        int unsigned p_redir;
        int unsigned p_rst;
        bit          wrap_first;
    } phase_t;

    logic clk = 1'b0;
    logic rst_n;
    instr_fetch_if bus ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    int          transfers = 0;
    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] held_addr;
    logic [31:0] d_rpc;
    bit          outstanding, dropping, can_issue, live_edge, d_ack, d_redir;
    int unsigned lat;
    logic [31:0] m_fetched, m_stall;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3, 0))
            0:       return 32'h0000_0103;
            1:       return 32'hFFFF_FFF8;
            2:       return RST_PC + 32'h0000_0041;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_cycle(input phase_t ph, input bit force_wrap);
        @(posedge clk);
        #1;
        // Apply the edge that just happened to the transaction model.
        if (live_edge) begin
            if (d_redir) begin
                exp_q.delete();
                m_pc = {d_rpc[31:2], 2'b00};
                if (outstanding && d_ack) begin
                    outstanding = 0;
                    dropping    = 0;
                end else if (outstanding) begin
                    dropping = 1;
                end
            end else if (outstanding && d_ack) begin
                if (!dropping) begin
                    exp_q.push_back('{m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
                outstanding = 0;
                dropping    = 0;
            end
        end
        if (outstanding) begin
            check("held imem_req", bus.imem_req, 1);
            check("held imem_addr", bus.imem_addr, held_addr);
        end else begin
            check("issue imem_req", bus.imem_req, can_issue);
            if (bus.imem_req) begin
                check("issue imem_addr", bus.imem_addr, m_pc);
                outstanding = 1;
                held_addr   = m_pc;
                lat         = $urandom_range(ph.lat_max, 0);
            end
        end
        if (!rst_n) begin
            rst_n = 1'b1;
        end else if (ph.p_rst != 0 && outstanding && $urandom_range(99, 0) < ph.p_rst) begin
            rst_n          = 1'b0;
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = $urandom;
            bus.redirect   = 1'b0;
            #1;
            check("rst imem_req", bus.imem_req, 0);
            check("rst if_valid", bus.if_valid, 0);
            check("rst imem_addr", bus.imem_addr, RST_PC);
            exp_q.delete();
            m_pc        = RST_PC;
            outstanding = 0;
            dropping    = 0;
            m_fetched   = '0;
            m_stall     = '0;
            live_edge   = 0;
            can_issue   = 0;
            d_ack       = 0;
            d_redir     = 0;
            return;
        end
        live_edge = 1;
        d_ack     = outstanding && (lat == 0);
        if (outstanding && lat > 0) lat--;
        bus.imem_ack   = d_ack;
        bus.imem_rdata = d_ack ? mem_word(bus.imem_addr) : $urandom;
        d_redir        = force_wrap || ($urandom_range(99, 0) < ph.p_redir);
        d_rpc          = force_wrap ? 32'hFFFF_FFFE : (d_redir ? pick_target() : $urandom);
        bus.redirect    = d_redir;
        bus.redirect_pc = d_rpc;
        bus.if_ready    = ($urandom_range(99, 0) < ph.p_ready);
        can_issue       = !outstanding && !d_redir && (exp_q.size() < DEPTH);
    endtask

    // Monitor: compares the decoder-side head against the scoreboard each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset if_valid", bus.if_valid, 0);
            check("reset if_instr", bus.if_instr, 0);
        end else begin
`ifdef FETCH_PERF_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_stall", perf_stall, m_stall);
`endif
            check("if_valid", bus.if_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("if_pc", bus.if_pc, exp_q[0].pc);
                check("if_instr", bus.if_instr, exp_q[0].instr);
                check("if_op", 32'(bus.if_op), 32'(exp_q[0].instr[31:26]));
                check("if_funct", 32'(bus.if_funct), 32'(exp_q[0].instr[5:0]));
                if (bus.if_ready) begin
                    void'(exp_q.pop_front());
                    transfers++;
                    m_fetched = m_fetched + 32'd1;
                end
            end else if (bus.if_ready) begin
                m_stall = m_stall + 32'd1;
            end
        end
    end

    phase_t phases[7];

    initial begin
        phases[0] = '{30, 100, 0, 0, 0, 0};
        phases[1] = '{20, 0, 0, 0, 0, 0};
        phases[2] = '{20, 100, 0, 0, 0, 0};
        phases[3] = '{20, 100, 0, 0, 0, 1};
        phases[4] = '{600, 60, 3, 8, 0, 0};
        phases[5] = '{600, 50, 4, 5, 3, 0};
        phases[6] = '{300, 30, 1, 15, 0, 0};

        rst_n           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready    = 1'b0;
        m_pc        = RST_PC;
        held_addr   = RST_PC;
        d_rpc       = '0;
        outstanding = 0;
        dropping    = 0;
        d_ack       = 0;
        d_redir     = 0;
        lat         = 0;
        m_fetched   = '0;
        m_stall     = '0;
        live_edge   = 1;
        can_issue   = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset imem_req", bus.imem_req, 0);
        check("reset imem_addr", bus.imem_addr, RST_PC);
        check("reset if_pc", bus.if_pc, 0);
        check("reset if_op", 32'(bus.if_op), 0);
        check("reset if_funct", 32'(bus.if_funct), 0);
        rst_n     = 1'b1;
        can_issue = 1;

        foreach (phases[p]) begin
            for (int unsigned c = 0; c < phases[p].cycles; c++) begin
                do_cycle(phases[p], phases[p].wrap_first && (c == 0));
            end
        end

        check("liveness transfers>=100", 32'(transfers >= 100), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
